// File: rtl/conv_frame_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// conv_frame_seq
//
// Frame sequencer placed upstream of the convolution controller's AXI-Stream
// slave port. It frames a raw pixel stream into lines of a configured geometry:
// SOF on m_tuser_o, EOL on m_tlast_o. An optional zero-pixel drain frame pushes
// the convolution datapath's retained tail rows out.
//
// Build option:
//   CONV_FRAME_SEQ_FLUSH_EN  defined   -> after each frame, FLUSH_ROWS x W zero
//                                         pixels are emitted before done_o.
//                            undefined -> ACTIVE returns straight to IDLE.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cfg_width_i, cfg_height_i  frame geometry, latched on an accepted start
//   start_i                    request one frame (sampled only in IDLE)
//   s_tvalid_i/s_tdata_i/s_tready_o            raw pixel input
//   m_tvalid_o/m_tdata_o/m_tuser_o/m_tlast_o/m_tready_i  framed pixel output
//   busy_o                     sequencer not idle
//   done_o                     one-cycle pulse after a frame fully completes
//   err_o                      sticky illegal-geometry flag, cleared on a good start
//   frame_cnt_o                completed-frame count, wraps at 2^16
// -----------------------------------------------------------------------------

package conv_pkg;
  typedef logic [7:0] pixel_t;
endpackage

module conv_frame_seq #(
  parameter int DIM_W      = 16,
  parameter int MIN_DIM    = 5,
  parameter int FLUSH_ROWS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIM_W-1:0] cfg_width_i,
  input  logic [DIM_W-1:0] cfg_height_i,
  input  logic             start_i,
  input  logic             s_tvalid_i,
  input  conv_pkg::pixel_t s_tdata_i,
  output logic             s_tready_o,
  output logic             m_tvalid_o,
  output conv_pkg::pixel_t m_tdata_o,
  output logic             m_tuser_o,
  output logic             m_tlast_o,
  input  logic             m_tready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [15:0]      frame_cnt_o
);

`ifdef CONV_FRAME_SEQ_FLUSH_EN
  localparam bit flush_en = 1'b1;
`else
  localparam bit flush_en = 1'b0;
`endif

  localparam logic [DIM_W-1:0] min_dim_c    = DIM_W'(MIN_DIM);
  localparam logic [DIM_W-1:0] flush_last_c = DIM_W'(FLUSH_ROWS - 1);
  localparam logic [DIM_W-1:0] one_c        = DIM_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] width_q, height_q;
  logic             err_q;
  logic             done_q;
  logic [15:0]      frame_cnt_q;

  logic             cfg_legal;
  logic             start_ok, start_bad;
  logic             hs;
  logic             last_col, last_row;
  logic [DIM_W-1:0] row_limit;
  logic             frame_done;

  assign cfg_legal = (cfg_width_i  >= min_dim_c) && (cfg_width_i  != '0) &&
                     (cfg_height_i >= min_dim_c) && (cfg_height_i != '0);

  // The drain frame reuses the col/row counters; only its row limit differs.
  assign row_limit = (state_q == FLUSH) ? flush_last_c : (height_q - one_c);
  assign last_col  = (col_q == (width_q - one_c));
  assign last_row  = (row_q == row_limit);

  // NOTE: every variable driven here gets a default before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    hs         = 1'b0;
    frame_done = 1'b0;
    s_tready_o = 1'b0;
    m_tvalid_o = 1'b0;
    m_tdata_o  = '0;
    m_tuser_o  = 1'b0;
    m_tlast_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (cfg_legal) begin
            start_ok = 1'b1;
            state_d  = ACTIVE;
          end else begin
            start_bad = 1'b1;
          end
        end
      end

      ACTIVE: begin
        m_tvalid_o = s_tvalid_i;
        s_tready_o = m_tready_i;
        m_tdata_o  = s_tdata_i;
        m_tuser_o  = (col_q == '0) && (row_q == '0);
        m_tlast_o  = last_col;
        hs         = s_tvalid_i & m_tready_i;
      end

      FLUSH: begin
        m_tvalid_o = 1'b1;
        m_tuser_o  = (col_q == '0) && (row_q == '0);
        m_tlast_o  = last_col;
        hs         = m_tready_i;
      end

      default: state_d = IDLE;
    endcase

    if (hs) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + one_c;
      end else begin
        col_d = col_q + one_c;
      end
      if (last_col && last_row) begin
        col_d = '0;
        row_d = '0;
        if (state_q == ACTIVE && flush_en) begin
          state_d = FLUSH;
        end else begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      width_q     <= '0;
      height_q    <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      done_q  <= frame_done;
      if (frame_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      // Geometry is captured only on an accepted start and then frozen.
      if (start_ok) begin
        width_q  <= cfg_width_i;
        height_q <= cfg_height_i;
        err_q    <= 1'b0;
      end else if (start_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule
